// File: rtl/pixmem_arbiter.sv
// Single-port pixel RAM arbiter: video reads have absolute priority, host writes
// are posted through a small FIFO, and host reads issue only once that FIFO is drained.
module pixmem_arbiter #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 634
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        vid_req,
  input  logic [ADDR_W-1:0]           vid_addr,
  output logic [DATA_W-1:0]           vid_data,
  output logic                        vid_valid,
  input  logic                        host_wr_valid,
  input  logic [ADDR_W-1:0]           host_wr_addr,
  input  logic [DATA_W-1:0]           host_wr_data,
  output logic                        host_wr_ready,
  input  logic                        host_rd_req,
  input  logic [ADDR_W-1:0]           host_rd_addr,
  output logic                        host_rd_busy,
  output logic                        host_rd_valid,
  output logic [DATA_W-1:0]           host_rd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        host_starve,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_we,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] LVL_ZERO = {LVL_W{1'b0}};
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [15:0] STARVE_LIM = 16'(STARVE_MAX);
  localparam logic [15:0] STARVE_PRE = 16'(STARVE_MAX - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_VID, ST_WR, ST_RD} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST} tag_t;

  state_t              state_r, state_next_s;
  tag_t                tag0_s, tag1_r;
  logic [ADDR_W-1:0]   fifo_addr_r [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_data_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]    count_r, count_next_s;
  logic                push_s, pop_s, wr_ready_r;
  logic                rd_pend_r, rd_busy_r, rd_accept_s;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [DATA_W-1:0]   vid_data_r, rd_data_r;
  logic                vid_valid_r, rd_valid_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic                mem_we_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [15:0]         starve_cnt_r;
  logic                starve_r, host_work_s, host_grant_s;

  // Slot grant: video first, then FIFO drain, then the pending host read.
  always_comb begin
    state_next_s = ST_IDLE;
    if (vid_req) begin
      state_next_s = ST_VID;
    end else if (count_r != LVL_ZERO) begin
      state_next_s = ST_WR;
    end else if (rd_pend_r) begin
      state_next_s = ST_RD;
    end else begin
      state_next_s = ST_IDLE;
    end
  end

  // Handshakes, FIFO occupancy and the tag of the command now on the RAM pins.
  always_comb begin
    push_s       = host_wr_valid && wr_ready_r;
    pop_s        = (state_next_s == ST_WR);
    rd_accept_s  = host_rd_req && !rd_busy_r;
    host_work_s  = (count_r != LVL_ZERO) || rd_pend_r;
    host_grant_s = pop_s || (state_next_s == ST_RD);
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + LVL_ONE;
      2'b01:   count_next_s = count_r - LVL_ONE;
      default: count_next_s = count_r;
    endcase
    case (state_r)
      ST_VID:  tag0_s = TAG_VID;
      ST_RD:   tag0_s = TAG_HOST;
      default: tag0_s = TAG_NONE;
    endcase
  end

  // Arbiter state and registered RAM command; idle slots keep the last address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_we_r    <= 1'b0;
      mem_wdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      case (state_next_s)
        ST_VID: begin
          mem_addr_r <= vid_addr;
          mem_we_r   <= 1'b0;
        end
        ST_WR: begin
          mem_addr_r  <= fifo_addr_r[rd_ptr_r];
          mem_wdata_r <= fifo_data_r[rd_ptr_r];
          mem_we_r    <= 1'b1;
        end
        ST_RD: begin
          mem_addr_r <= rd_addr_r;
          mem_we_r   <= 1'b0;
        end
        default: mem_we_r <= 1'b0;
      endcase
    end
  end

  // Posted host write FIFO; ready is registered from the next-cycle occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= LVL_ZERO;
      wr_ready_r <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_r[i] <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (push_s) begin
        fifo_addr_r[wr_ptr_r] <= host_wr_addr;
        fifo_data_r[wr_ptr_r] <= host_wr_data;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r    <= count_next_s;
      wr_ready_r <= (count_next_s != LVL_FULL);
    end
  end

  // Host read: pending until issued, busy until its data returns.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_pend_r <= 1'b0;
      rd_busy_r <= 1'b0;
      rd_addr_r <= {ADDR_W{1'b0}};
    end else if (rd_accept_s) begin
      rd_pend_r <= 1'b1;
      rd_busy_r <= 1'b1;
      rd_addr_r <= host_rd_addr;
    end else begin
      if (state_next_s == ST_RD) begin
        rd_pend_r <= 1'b0;
      end
      if (tag1_r == TAG_HOST) begin
        rd_busy_r <= 1'b0;
      end
    end
  end

  // Second tag stage lines up with mem_rdata and steers it to its requester.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag1_r      <= TAG_NONE;
      vid_valid_r <= 1'b0;
      vid_data_r  <= {DATA_W{1'b0}};
      rd_valid_r  <= 1'b0;
      rd_data_r   <= {DATA_W{1'b0}};
    end else begin
      tag1_r      <= tag0_s;
      vid_valid_r <= (tag1_r == TAG_VID);
      rd_valid_r  <= (tag1_r == TAG_HOST);
      if (tag1_r == TAG_VID) begin
        vid_data_r <= mem_rdata;
      end
      if (tag1_r == TAG_HOST) begin
        rd_data_r <= mem_rdata;
      end
    end
  end

  // Starvation counter saturates at the limit so the warning fires only once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt_r <= 16'd0;
      starve_r     <= 1'b0;
    end else if (!host_work_s || host_grant_s) begin
      starve_cnt_r <= 16'd0;
      starve_r     <= 1'b0;
    end else if (starve_cnt_r != STARVE_LIM) begin
      starve_cnt_r <= starve_cnt_r + 16'd1;
      starve_r     <= (starve_cnt_r == STARVE_PRE);
    end else begin
      starve_r <= 1'b0;
    end
  end

  assign vid_data      = vid_data_r;
  assign vid_valid     = vid_valid_r;
  assign host_wr_ready = wr_ready_r;
  assign host_rd_busy  = rd_busy_r;
  assign host_rd_valid = rd_valid_r;
  assign host_rd_data  = rd_data_r;
  assign fifo_level    = count_r;
  assign host_starve   = starve_r;
  assign mem_addr      = mem_addr_r;
  assign mem_we        = mem_we_r;
  assign mem_wdata     = mem_wdata_r;

endmodule

// File: tb/tb_pixmem_arbiter.sv
// Directed bench for pixmem_arbiter: a vector table for single-cycle behaviour plus
// sequences for video streaming, FIFO full, read-after-write, starvation and reset.
module tb_pixmem_arbiter;
  localparam int AW = 9;
  localparam int DW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          vid_req, vid_valid, host_wr_valid, host_wr_ready;
  logic          host_rd_req, host_rd_busy, host_rd_valid, host_starve, mem_we;
  logic [AW-1:0] vid_addr, host_wr_addr, host_rd_addr, mem_addr;
  logic [DW-1:0] vid_data, host_wr_data, host_rd_data, mem_wdata, mem_rdata;
  logic [2:0]    fifo_level;
  logic [DW-1:0] ram [0:511];
  logic          load = 1'b1;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  pixmem_arbiter dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .host_wr_valid(host_wr_valid), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_wr_ready(host_wr_ready), .host_rd_req(host_rd_req), .host_rd_addr(host_rd_addr),
    .host_rd_busy(host_rd_busy), .host_rd_valid(host_rd_valid), .host_rd_data(host_rd_data),
    .fifo_level(fifo_level), .host_starve(host_starve), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Write-first single-port RAM model, preloaded with addr[1:0].
  always @(posedge clk) begin
    if (load) begin
      for (int a = 0; a < 512; a++) ram[a] <= 2'(a);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
    end
  end

  typedef struct {
    int vr, va, wv, wa, wd, rr, ra;
    int lvl, rdy, we, ma, vv, vd, rv, rd, bsy;
  } vec_t;
  vec_t tbl [23];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    vid_req = 1'b0; vid_addr = '0;
    host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    host_rd_req = 1'b0; host_rd_addr = '0;
  endtask

  function automatic int out_bits();
    return int'({vid_valid, vid_data, host_rd_valid, host_rd_data, host_rd_busy, host_wr_ready,
                 fifo_level, host_starve, mem_addr, mem_we, mem_wdata});
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nst, st_at, gaps, bad, pulses;
    //            vr va  wv wa wd rr ra  lvl rdy we ma  vv vd rv rd bsy
    tbl[0]  = '{0, 0,  1, 10, 1, 0, 0,  1, 1, 0, 241, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0,  1, 11, 2, 0, 0,  1, 1, 1, 10,  0, 1, 0, 0, 0};
    tbl[2]  = '{0, 0,  1, 12, 3, 0, 0,  1, 1, 1, 11,  0, 1, 0, 0, 0};
    tbl[3]  = '{0, 0,  1, 13, 0, 0, 0,  1, 1, 1, 12,  0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0,  1, 14, 1, 0, 0,  1, 1, 1, 13,  0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 1, 14,  0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 14,  0, 1, 0, 0, 0};
    tbl[7]  = '{1, 12, 0, 0,  0, 0, 0,  0, 1, 0, 12,  0, 1, 0, 0, 0};
    tbl[8]  = '{1, 14, 0, 0,  0, 0, 0,  0, 1, 0, 14,  0, 1, 0, 0, 0};
    tbl[9]  = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 14,  1, 3, 0, 0, 0};
    tbl[10] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 14,  1, 1, 0, 0, 0};
    tbl[11] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 14,  0, 1, 0, 0, 0};
    tbl[12] = '{0, 0,  0, 0,  0, 1, 11, 0, 1, 0, 14,  0, 1, 0, 0, 1};
    tbl[13] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 11,  0, 1, 0, 0, 1};
    tbl[14] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 11,  0, 1, 0, 0, 1};
    tbl[15] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 11,  0, 1, 1, 2, 0};
    tbl[16] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 11,  0, 1, 0, 2, 0};
    tbl[17] = '{0, 0,  1, 30, 1, 0, 0,  1, 1, 0, 11,  0, 1, 0, 2, 0};
    tbl[18] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 1, 30,  0, 1, 0, 2, 0};
    tbl[19] = '{1, 30, 0, 0,  0, 0, 0,  0, 1, 0, 30,  0, 1, 0, 2, 0};
    tbl[20] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 30,  0, 1, 0, 2, 0};
    tbl[21] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 30,  1, 1, 0, 2, 0};
    tbl[22] = '{0, 0,  0, 0,  0, 0, 0,  0, 1, 0, 30,  0, 1, 0, 2, 0};

    idle_in();
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs zero", out_bits(), 0);
    load = 1'b0;
    @(negedge clk) reset = 1'b1;
    cyc();
    chk("ready after release", int'(host_wr_ready), 1);
    chk("level after release", int'(fifo_level), 0);

    // Continuous video stream: 2-cycle latency, no bubbles.
    for (int i = 0; i < 245; i++) begin
      vid_req  = (i < 242);
      vid_addr = 9'(i);
      cyc();
      chk($sformatf("stream valid %0d", i), int'(vid_valid), (i >= 2 && i <= 243) ? 1 : 0);
      if (i >= 2 && i <= 243) chk($sformatf("stream data %0d", i), int'(vid_data), (i - 2) & 3);
    end
    idle_in();
    repeat (2) cyc();

    for (int i = 0; i < 23; i++) begin
      vid_req = 1'(tbl[i].vr); vid_addr = 9'(tbl[i].va);
      host_wr_valid = 1'(tbl[i].wv); host_wr_addr = 9'(tbl[i].wa); host_wr_data = 2'(tbl[i].wd);
      host_rd_req = 1'(tbl[i].rr); host_rd_addr = 9'(tbl[i].ra);
      cyc();
      chk($sformatf("vec%0d level", i), int'(fifo_level), tbl[i].lvl);
      chk($sformatf("vec%0d ready", i), int'(host_wr_ready), tbl[i].rdy);
      chk($sformatf("vec%0d mem_we", i), int'(mem_we), tbl[i].we);
      chk($sformatf("vec%0d mem_addr", i), int'(mem_addr), tbl[i].ma);
      chk($sformatf("vec%0d vid_valid", i), int'(vid_valid), tbl[i].vv);
      chk($sformatf("vec%0d vid_data", i), int'(vid_data), tbl[i].vd);
      chk($sformatf("vec%0d rd_valid", i), int'(host_rd_valid), tbl[i].rv);
      chk($sformatf("vec%0d rd_data", i), int'(host_rd_data), tbl[i].rd);
      chk($sformatf("vec%0d rd_busy", i), int'(host_rd_busy), tbl[i].bsy);
    end
    idle_in();
    cyc();
    chk("ram[10]", int'(ram[10]), 1);
    chk("ram[11]", int'(ram[11]), 2);
    chk("ram[12]", int'(ram[12]), 3);
    chk("ram[13]", int'(ram[13]), 0);
    chk("ram[14]", int'(ram[14]), 1);
    chk("ram[30]", int'(ram[30]), 1);

    // FIFO full under video load; the fifth push must be dropped.
    vid_req = 1'b1; vid_addr = 9'd300;
    for (int k = 0; k < 5; k++) begin
      host_wr_valid = 1'b1;
      host_wr_addr  = 9'(40 + k);
      host_wr_data  = (k == 0) ? 2'd1 : (k == 1) ? 2'd2 : (k == 2) ? 2'd3 : (k == 3) ? 2'd1 : 2'd3;
      cyc();
    end
    chk("full level", int'(fifo_level), 4);
    chk("full ready", int'(host_wr_ready), 0);
    host_wr_valid = 1'b0;
    vid_req = 1'b0;
    cyc();
    chk("drain1 level", int'(fifo_level), 3);
    chk("drain1 ready", int'(host_wr_ready), 1);
    repeat (3) cyc();
    chk("drained level", int'(fifo_level), 0);
    repeat (2) cyc();
    chk("ram[40]", int'(ram[40]), 1);
    chk("ram[41]", int'(ram[41]), 2);
    chk("ram[42]", int'(ram[42]), 3);
    chk("ram[43]", int'(ram[43]), 1);
    chk("ram[44] untouched", int'(ram[44]), 0);

    // Read-after-write behind ten cycles of video.
    vid_req = 1'b1; vid_addr = 9'd301;
    host_wr_valid = 1'b1; host_wr_addr = 9'd20; host_wr_data = 2'd3;
    cyc();
    host_wr_valid = 1'b0;
    host_rd_req = 1'b1; host_rd_addr = 9'd20;
    cyc();
    host_rd_req = 1'b0;
    chk("raw busy accepted", int'(host_rd_busy), 1);
    for (int j = 0; j < 8; j++) begin
      cyc();
      chk($sformatf("raw busy wait %0d", j), int'(host_rd_busy), 1);
      chk($sformatf("raw no valid %0d", j), int'(host_rd_valid), 0);
    end
    vid_req = 1'b0;
    pulses = 0; bad = 0;
    for (int j = 0; j < 20; j++) begin
      cyc();
      if (host_rd_valid) begin
        pulses++;
        chk("raw data", int'(host_rd_data), 3);
        chk("raw busy cleared", int'(host_rd_busy), 0);
      end else if (pulses == 0 && !host_rd_busy) begin
        bad++;
      end
    end
    chk("raw valid pulses", pulses, 1);
    chk("raw busy dropped early", bad, 0);

    // Starvation: one pending entry behind 700 cycles of video.
    nst = 0; st_at = -1; gaps = 0; bad = 0;
    for (int k = 0; k <= 700; k++) begin
      vid_req = 1'b1;
      vid_addr = 9'(256 + (k % 200));
      host_wr_valid = (k == 0);
      host_wr_addr = 9'd50; host_wr_data = 2'd3;
      cyc();
      if (host_starve) begin
        nst++;
        st_at = k;
      end
      if (k >= 2) begin
        if (!vid_valid) gaps++;
        else if (int'(vid_data) != (((k - 2) % 200) & 3)) bad++;
      end
    end
    chk("starve pulse count", nst, 1);
    chk("starve denied cycle", st_at, 634);
    chk("starve video gaps", gaps, 0);
    chk("starve video data", bad, 0);
    idle_in();
    repeat (4) cyc();
    chk("starve drained level", int'(fifo_level), 0);
    chk("ram[50]", int'(ram[50]), 3);

    // Reset while two writes are queued and a host read is in flight.
    host_rd_req = 1'b1; host_rd_addr = 9'd5;
    cyc();
    host_rd_req = 1'b0;
    host_wr_valid = 1'b1; host_wr_addr = 9'd60; host_wr_data = 2'd3;
    cyc();
    host_wr_addr = 9'd61;
    vid_req = 1'b1; vid_addr = 9'd7;
    cyc();
    chk("pre-reset level", int'(fifo_level), 2);
    reset = 1'b0;
    #1;
    chk("mid reset outputs zero", out_bits(), 0);
    idle_in();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    pulses = 0;
    for (int j = 0; j < 8; j++) begin
      cyc();
      if (host_rd_valid || vid_valid) pulses++;
    end
    chk("no stale valids", pulses, 0);
    chk("post reset level", int'(fifo_level), 0);
    chk("post reset ready", int'(host_wr_ready), 1);
    chk("ram[60] untouched", int'(ram[60]), 0);
    chk("ram[61] untouched", int'(ram[61]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
